ss_adc_ctrl: RTL and testbench
==============================

# ss_adc_ctrl

Parametrised single-slope ADC conversion controller: sequences ramp reset, ramp enable and counting, and captures the count when the analog comparator trips. It adds over the first-generation control FSM:
- configurable counter width;
- multi-cycle ramp reset;
- comparator synchroniser;
- overflow detection;
- power-of-two sample averaging;
- continuous (free-running) mode.

It sits between the digital top and the analog ramp/comparator macro.

## Interface
- `CNT_W`, default 8: conversion counter width; full scale is 2^CNT_W-1.
- `RST_CYCLES`, default 2: cycles `ramp_reset` is held before each ramp (≥1).
- `SYNC_STAGES`, default 2: flops in the `comp_out` synchroniser (≥2).
- `AVG_LOG2`, default 0: 2^AVG_LOG2 samples averaged per result (0 = no averaging).

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `comp_out` in 1: raw comparator output, asynchronous; 1 = ramp crossed input.
- `restart` in 1: level request to begin a conversion.
- `cont` in 1: continuous mode; sampled in DONE.
- `ramp_reset` out 1: holds ramp capacitor discharged.
- `ramp_en` out 1: ramp integrating.
- `busy` out 1: conversion in progress.
- `valid` out 1: one-cycle result strobe.
- `data` out CNT_W: averaged result; held between strobes.
- `overflow` out 1: result contains a saturated sample; qualified by `valid`, held with `data`.

## Operation
- States: IDLE, RAMP_RST, COUNT, DONE.
- Outputs are decoded from registered state or come straight from registers. There are no combinational paths from inputs to outputs.
- Reset (`rstn`=0), applied asynchronously:
  - state = IDLE;
  - `ramp_reset`=1;
  - `ramp_en`=0, `busy`=0, `valid`=0;
  - `data`=0, `overflow`=0;
  - the accumulator, sample counter and synchroniser are cleared.
- IDLE:
  - `ramp_reset`=1.
  - `restart`=1 moves to RAMP_RST and clears the accumulator, sample index and sticky overflow.
- RAMP_RST:
  - `ramp_reset`=1, `busy`=1.
  - Stays for exactly RST_CYCLES cycles, then goes to COUNT with count=0.
- COUNT:
  - `ramp_en`=1, `ramp_reset`=0, `busy`=1.
  - count increments by 1 per cycle; cycle k of COUNT has count=k.
  - Sample ends on the first COUNT cycle where synchronised `comp_s`=1; the sample value is k. No synchroniser-latency compensation is applied.
  - If count reaches 2^CNT_W-1 with `comp_s`=0, the sample value is 2^CNT_W-1 and sticky overflow is set. The counter never wraps.
  - On sample end the value is added into a (CNT_W+AVG_LOG2)-bit accumulator. This accumulator cannot overflow.
  - If fewer than 2^AVG_LOG2 samples have been taken, go back to RAMP_RST. Otherwise go to DONE.
- DONE:
  - `busy`=1 and `valid`=1 for this single cycle.
  - `data` = accumulator >> AVG_LOG2 (truncating); `overflow` = sticky flag. Both are registered on entry to DONE.
  - `cont`=1: go to RAMP_RST and clear the accumulator and flags; `busy` stays 1.
  - `cont`=0: go to IDLE.
- `restart` is ignored outside IDLE.
- `comp_s` already high when COUNT is entered gives sample 0.
- `rstn` low mid-conversion aborts immediately; the partial result is discarded.

## Timing
- `restart` sampled high in IDLE at edge T:
  - RAMP_RST occupies T+1 … T+RST_CYCLES.
  - COUNT cycle k=0 is at T+RST_CYCLES+1.
- A sample ending at COUNT cycle k, with AVG_LOG2=0, gives DONE (`valid`) at T+RST_CYCLES+k+2.
- `comp_out` edge to `comp_s`: SYNC_STAGES cycles.
- Each additional averaged sample costs RST_CYCLES+k+1 cycles.
- `busy` rises at T+1 and falls the cycle after DONE when `cont`=0.
- Continuous mode: DONE is followed directly by RAMP_RST with no IDLE gap.

## Structure
- Package `ss_adc_pkg`: `state_e` typedef (IDLE, RAMP_RST, COUNT, DONE).
- Sub-module `sync_ff`: parametrised-depth synchroniser with asynchronous active-low reset, used for `comp_out`.
- Body: FSM, RST_CYCLES down-counter, CNT_W counter, accumulator, sample index, result/overflow registers.

## Test plan
All scenarios use CNT_W=8, RST_CYCLES=2, SYNC_STAGES=2, AVG_LOG2=0 unless stated.
- `restart` at cycle 0, `comp_s` first high at COUNT k=100 → `valid` at cycle 104, `data`=100, `overflow`=0; `busy` cycles 1–104.
- `comp_out` held 0 → `data`=255, `overflow`=1, `valid` at cycle 259; count never wraps.
- AVG_LOG2=2, samples 10, 11, 12, 13 → single `valid`, `data`=11 (46>>2), `overflow`=0, four RAMP_RST phases seen on `ramp_reset`.
- `cont`=1 for two conversions → two `valid` pulses, `busy` never low between them; `cont`=0 before the second DONE → return to IDLE, `busy`=0 next cycle.
- `rstn` pulsed low at COUNT k=50 → same cycle `ramp_reset`=1, `ramp_en`=0, `busy`=0, `data`=0; a `restart` pulse during COUNT in a separate run → ignored, result unaffected.
- `comp_out` high before `restart` → `data`=0, `valid` at cycle 4.

Source files
------------

// File: rtl/ss_adc_pkg.sv
// Shared types for the single-slope ADC conversion controller.
package ss_adc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP_RST = 2'd1,
        COUNT    = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Sample-index width; a zero-width index is not legal, so floor at one bit.
    function automatic int idx_w(input int avg_log2);
        return (avg_log2 > 0) ? avg_log2 : 1;
    endfunction

endpackage

// File: rtl/ss_adc_ctrl_if.sv
// Control/result bundle between the digital top and the ramp/comparator macro.
interface ss_adc_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             comp_out;
    logic             restart;
    logic             cont;
    logic             ramp_reset;
    logic             ramp_en;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] data;
    logic             overflow;

    modport master (
        input  comp_out, restart, cont,
        output ramp_reset, ramp_en, busy, valid, data, overflow
    );

    modport slave (
        output comp_out, restart, cont,
        input  ramp_reset, ramp_en, busy, valid, data, overflow
    );
endinterface

// File: rtl/ss_adc_ctrl_sync_ff.sv
// Multi-flop synchroniser for an asynchronous level; latency STAGES cycles.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift <= '0;
        end else begin
            shift <= {shift[STAGES-2:0], d};
        end
    end

    assign q = shift[STAGES-1];
endmodule

// File: rtl/ss_adc_ctrl.sv
// Single-slope ADC sequencer: ramp reset, count until comparator trips, average 2^AVG_LOG2 samples.
// Result strobes RST_CYCLES+k+2 cycles after restart per sample; no backpressure, outputs are all registered.
module ss_adc_ctrl
    import ss_adc_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int RST_CYCLES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int AVG_LOG2    = 0
) (
    input  logic         clk,
    input  logic         rstn,
    ss_adc_ctrl_if.master adc
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = idx_w(AVG_LOG2);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL     = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);

    state_e           state;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic             ovf;
    logic             comp_s;

    logic             ramp_reset_q;
    logic             ramp_en_q;
    logic             busy_q;
    logic             valid_q;
    logic [CNT_W-1:0] data_q;
    logic             overflow_q;

    logic             smp_end;
    logic             smp_sat;
    logic [ACC_W-1:0] acc_sum;

    sync_ff #(.STAGES(SYNC_STAGES)) u_comp_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (adc.comp_out),
        .q    (comp_s)
    );

    // The sample value is the current count whether the comparator tripped or the counter pinned at full scale.
    assign smp_sat = (cnt == FULL) && !comp_s;
    assign smp_end = (state == COUNT) && (comp_s || (cnt == FULL));
    assign acc_sum = acc + ACC_W'(cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            cnt          <= '0;
            acc          <= '0;
            idx          <= '0;
            ovf          <= 1'b0;
            ramp_reset_q <= 1'b1;
            ramp_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (adc.restart) begin
                        state   <= RAMP_RST;
                        rst_cnt <= RC_LOAD;
                        acc     <= '0;
                        idx     <= '0;
                        ovf     <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RAMP_RST: begin
                    if (rst_cnt == '0) begin
                        state        <= COUNT;
                        cnt          <= '0;
                        ramp_reset_q <= 1'b0;
                        ramp_en_q    <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                COUNT: begin
                    if (smp_end) begin
                        acc          <= acc_sum;
                        ovf          <= ovf | smp_sat;
                        ramp_en_q    <= 1'b0;
                        ramp_reset_q <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state      <= DONE;
                            valid_q    <= 1'b1;
                            data_q     <= CNT_W'(acc_sum >> AVG_LOG2);
                            overflow_q <= ovf | smp_sat;
                        end else begin
                            state   <= RAMP_RST;
                            rst_cnt <= RC_LOAD;
                            idx     <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (adc.cont) begin
                        state   <= RAMP_RST;
                        rst_cnt <= RC_LOAD;
                        acc     <= '0;
                        idx     <= '0;
                        ovf     <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign adc.ramp_reset = ramp_reset_q;
    assign adc.ramp_en    = ramp_en_q;
    assign adc.busy       = busy_q;
    assign adc.valid      = valid_q;
    assign adc.data       = data_q;
    assign adc.overflow   = overflow_q;
endmodule

// File: tb/tb_ss_adc_ctrl.sv
// Directed bench for ss_adc_ctrl: one plain instance and one averaging (AVG_LOG2=2) instance.
module tb_ss_adc_ctrl;
    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ss_adc_ctrl_if #(.CNT_W(8)) a_if ();
    ss_adc_ctrl_if #(.CNT_W(8)) b_if ();

    ss_adc_ctrl #(.CNT_W(8), .RST_CYCLES(2), .SYNC_STAGES(2), .AVG_LOG2(0)) dut_a (
        .clk (clk), .rstn (rstn), .adc (a_if)
    );
    ss_adc_ctrl #(.CNT_W(8), .RST_CYCLES(2), .SYNC_STAGES(2), .AVG_LOG2(2)) dut_b (
        .clk (clk), .rstn (rstn), .adc (b_if)
    );

    // Comparator model: raises comp_out so that the synchronised trip lands on COUNT cycle vin[sample].
    logic tst_cmp_a = 1'b0;
    logic mdl_cmp_a = 1'b0;
    logic mdl_cmp_b = 1'b0;
    bit   mdl_a     = 1'b0;
    bit   mdl_b     = 1'b0;
    int   vin_a[4];
    int   vin_b[4];
    int   e_a = 0, e_b = 0, smp_a = 0, smp_b = 0;
    logic en_a_q = 1'b0, en_b_q = 1'b0;

    assign a_if.comp_out = mdl_a ? mdl_cmp_a : tst_cmp_a;
    assign b_if.comp_out = mdl_cmp_b;

    always @(posedge clk) begin
        #1;
        if (!mdl_a) smp_a = 0;
        else begin
            if (a_if.ramp_en) begin
                e_a = en_a_q ? e_a + 1 : 0;
                if (smp_a < 4 && e_a == vin_a[smp_a] - 2) mdl_cmp_a = 1'b1;
            end else if (en_a_q) smp_a = smp_a + 1;
            if (a_if.ramp_reset) mdl_cmp_a = 1'b0;
        end
        en_a_q = a_if.ramp_en;
        if (!mdl_b) smp_b = 0;
        else begin
            if (b_if.ramp_en) begin
                e_b = en_b_q ? e_b + 1 : 0;
                if (smp_b < 4 && e_b == vin_b[smp_b] - 2) mdl_cmp_b = 1'b1;
            end else if (en_b_q) smp_b = smp_b + 1;
            if (b_if.ramp_reset) mdl_cmp_b = 1'b0;
        end
        en_b_q = b_if.ramp_en;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One conversion on dut_a. Cycle numbering: the restart edge is cycle 0; n counts edges since it, cycle = n+1.
    // k: COUNT index whose synchronised comparator is high (-1 = never); rs_at: n at which to pulse restart.
    task automatic conv_a(input int k, input int rs_at, output int vcyc, output int bad);
        vcyc = -1;
        bad  = 0;
        a_if.restart = 1'b1;
        @(posedge clk); #1;
        a_if.restart = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (n == 2) chk("count_entry_ramp", {a_if.ramp_en, a_if.ramp_reset}, 2);
            if (a_if.valid) begin
                vcyc = n + 1;
                break;
            end
            if (!a_if.busy) bad++;
            if (n == k) tst_cmp_a = 1'b1;
            a_if.restart = (n == rs_at);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vc, bb, nv, nf, vc2, busy_after;
        int d1, d2, ov;
        logic rr_q;

        rstn = 1'b0;
        a_if.restart = 1'b0; a_if.cont = 1'b0;
        b_if.restart = 1'b0; b_if.cont = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ramp_reset", a_if.ramp_reset, 1);
        chk("rst_ramp_en",    a_if.ramp_en,    0);
        chk("rst_busy",       a_if.busy,       0);
        chk("rst_valid",      a_if.valid,      0);
        chk("rst_data",       a_if.data,       0);
        chk("rst_overflow",   a_if.overflow,   0);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Basic conversion, trip at k=100.
        conv_a(100, -1, vc, bb);
        chk("k100_valid_cyc", vc, 104);
        chk("k100_data", a_if.data, 100);
        chk("k100_ovf", a_if.overflow, 0);
        chk("k100_busy_gap", bb, 0);
        @(posedge clk); #1;
        chk("k100_busy_fall", a_if.busy, 0);
        tst_cmp_a = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Comparator never trips: saturate at full scale.
        conv_a(-1, -1, vc, bb);
        chk("sat_valid_cyc", vc, 259);
        chk("sat_data", a_if.data, 255);
        chk("sat_ovf", a_if.overflow, 1);
        repeat (5) @(posedge clk); #1;
        chk("sat_hold_data", a_if.data, 255);
        chk("sat_hold_ovf", a_if.overflow, 1);
        chk("sat_hold_valid", a_if.valid, 0);

        // Comparator already high before restart gives sample 0.
        tst_cmp_a = 1'b1;
        repeat (3) @(posedge clk); #1;
        conv_a(-1, -1, vc, bb);
        chk("early_valid_cyc", vc, 4);
        chk("early_data", a_if.data, 0);
        chk("early_ovf", a_if.overflow, 0);
        tst_cmp_a = 1'b0;
        repeat (3) @(posedge clk); #1;

        // restart pulsed mid-COUNT must be ignored.
        conv_a(30, 10, vc, bb);
        chk("rsig_valid_cyc", vc, 34);
        chk("rsig_data", a_if.data, 30);
        chk("rsig_busy_gap", bb, 0);
        tst_cmp_a = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Asynchronous abort at COUNT k=50 (cycle 53).
        a_if.restart = 1'b1;
        @(posedge clk); #1;
        a_if.restart = 1'b0;
        repeat (52) @(posedge clk); #1;
        chk("abort_pre_en", a_if.ramp_en, 1);
        rstn = 1'b0;
        #1;
        chk("abort_ramp_reset", a_if.ramp_reset, 1);
        chk("abort_ramp_en", a_if.ramp_en, 0);
        chk("abort_busy", a_if.busy, 0);
        chk("abort_data", a_if.data, 0);
        #1 rstn = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("abort_stays_idle", a_if.busy, 0);

        // Continuous mode: samples 5 then 7, cont dropped after the first DONE.
        vin_a[0] = 5; vin_a[1] = 7; vin_a[2] = 0; vin_a[3] = 0;
        mdl_a = 1'b1;
        a_if.cont = 1'b1;
        a_if.restart = 1'b1;
        @(posedge clk); #1;
        a_if.restart = 1'b0;
        nv = 0; bb = 0; vc = -1; vc2 = -1; d1 = -1; d2 = -1; busy_after = -1;
        for (int n = 0; n < 40; n++) begin
            if (a_if.valid) begin
                nv++;
                if (nv == 1) begin vc = n + 1; d1 = a_if.data; end
                else begin vc2 = n + 1; d2 = a_if.data; end
            end else if (nv == 1) a_if.cont = 1'b0;
            if (vc2 < 0 && !a_if.busy) bb++;
            if (vc2 > 0 && n == vc2) busy_after = a_if.busy;
            @(posedge clk); #1;
        end
        chk("cont_nvalid", nv, 2);
        chk("cont_valid1_cyc", vc, 9);
        chk("cont_data1", d1, 5);
        chk("cont_valid2_cyc", vc2, 20);
        chk("cont_data2", d2, 7);
        chk("cont_busy_gap", bb, 0);
        chk("cont_busy_fall", busy_after, 0);
        mdl_a = 1'b0;
        a_if.cont = 1'b0;

        // Averaging of 10,11,12,13 -> 46>>2 = 11.
        vin_b[0] = 10; vin_b[1] = 11; vin_b[2] = 12; vin_b[3] = 13;
        mdl_b = 1'b1;
        b_if.restart = 1'b1;
        @(posedge clk); #1;
        b_if.restart = 1'b0;
        nv = 0; nf = 0; bb = 0; vc = -1; d1 = -1; ov = -1;
        rr_q = b_if.ramp_reset;
        for (int n = 0; n < 80; n++) begin
            if (b_if.valid) begin
                nv++; vc = n + 1; d1 = b_if.data; ov = b_if.overflow;
            end
            if (rr_q && !b_if.ramp_reset) nf++;
            rr_q = b_if.ramp_reset;
            if (vc < 0 && !b_if.busy) bb++;
            @(posedge clk); #1;
        end
        chk("avg_nvalid", nv, 1);
        chk("avg_valid_cyc", vc, 59);
        chk("avg_data", d1, 11);
        chk("avg_ovf", ov, 0);
        chk("avg_ramp_phases", nf, 4);
        chk("avg_busy_gap", bb, 0);
        mdl_b = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
